// File: rtl/bus1_arbiter.sv
// Two-requester round-robin front end for a narrow cache bus (A1/D1/C1).
// Each requester raises REQ_r and holds it until its DONE_r pulse. DONE_r is a
// single-cycle completion strobe carrying RDATA_r/ERR_r. The arbiter never
// pushes back, so there is no separate ready. The latched transfer runs to
// completion even if REQ_r drops early. Only an asynchronous reset cancels it.
module bus1_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        REQ_0,
    input  logic [2:0]  CMD_0,
    input  logic [18:0] ADDR_0,
    input  logic [31:0] WDATA_0,
    output logic        DONE_0,
    output logic [31:0] RDATA_0,
    output logic        ERR_0,
    input  logic        REQ_1,
    input  logic [2:0]  CMD_1,
    input  logic [18:0] ADDR_1,
    input  logic [31:0] WDATA_1,
    output logic        DONE_1,
    output logic [31:0] RDATA_1,
    output logic        ERR_1,
    output logic [14:0] A1,
    inout  wire  [15:0] D1,
    inout  wire  [2:0]  C1,
    output logic [2:0]  dbg_state
);

    localparam logic [2:0] CMD_NOP     = 3'd0;
    localparam logic [2:0] CMD_READ8   = 3'd1;
    localparam logic [2:0] CMD_READ16  = 3'd2;
    localparam logic [2:0] CMD_READ32  = 3'd3;
    localparam logic [2:0] CMD_WRITE8  = 3'd5;
    localparam logic [2:0] CMD_WRITE16 = 3'd6;
    localparam logic [2:0] CMD_WRITE32 = 3'd7;
    localparam logic [2:0] C1_RESPONSE = 3'd7;

    // Counter only needs to reach TIMEOUT-1: the last waiting cycle decides.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD1 = 3'd1,
        ST_CMD2 = 3'd2,
        ST_WAIT = 3'd3,
        ST_RD2  = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             last_gnt;
    logic             owner;
    logic [2:0]       cmd_q;
    logic [18:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic             err_q;
    logic [CNT_W-1:0] tcnt;

    logic             gnt_any;
    logic             gnt_id;
    logic [2:0]       gnt_cmd;
    logic             resp_seen;
    logic             timeout_hit;
    logic             c1_oe;
    logic             d1_oe;
    logic [15:0]      d1_out;
    logic             fin;

    // On a tie the requester that was not served last wins.
    assign gnt_any     = REQ_0 | REQ_1;
    assign gnt_id      = (REQ_0 & REQ_1) ? ~last_gnt : REQ_1;
    assign gnt_cmd     = gnt_id ? CMD_1 : CMD_0;
    assign resp_seen   = (C1 == C1_RESPONSE);
    assign timeout_hit = (tcnt == CNT_LAST);

    assign C1 = c1_oe ? cmd_q  : 3'bzzz;
    assign D1 = d1_oe ? d1_out : 16'hzzzz;

    assign dbg_state = state;

    // Completion outputs exist only in FIN and only for the owning requester.
    assign DONE_0  = fin & ~owner;
    assign DONE_1  = fin & owner;
    assign ERR_0   = fin & ~owner & err_q;
    assign ERR_1   = fin & owner & err_q;
    assign RDATA_0 = (fin & ~owner) ? rdata_q : 32'd0;
    assign RDATA_1 = (fin & owner)  ? rdata_q : 32'd0;

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and bus drive decode.
    always_comb begin
        state_next = state;
        A1         = 15'd0;
        c1_oe      = 1'b0;
        d1_oe      = 1'b0;
        d1_out     = 16'd0;
        fin        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_any) begin
                    state_next = (gnt_cmd == CMD_NOP) ? ST_FIN : ST_CMD1;
                end
            end
            ST_CMD1: begin
                c1_oe = 1'b1;
                A1    = addr_q[18:4];
                case (cmd_q)
                    CMD_WRITE8: begin
                        d1_oe  = 1'b1;
                        d1_out = {8'h00, wdata_q[7:0]};
                    end
                    CMD_WRITE16: begin
                        d1_oe  = 1'b1;
                        d1_out = {wdata_q[7:0], wdata_q[15:8]};
                    end
                    CMD_WRITE32: begin
                        d1_oe  = 1'b1;
                        d1_out = {wdata_q[23:16], wdata_q[31:24]};
                    end
                    default: begin
                        d1_oe = 1'b0;
                    end
                endcase
                state_next = ST_CMD2;
            end
            ST_CMD2: begin
                c1_oe = 1'b1;
                A1    = {11'd0, addr_q[3:0]};
                if (cmd_q == CMD_WRITE32) begin
                    d1_oe  = 1'b1;
                    d1_out = {wdata_q[7:0], wdata_q[15:8]};
                end
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (resp_seen) begin
                    state_next = (cmd_q == CMD_READ32) ? ST_RD2 : ST_FIN;
                end else if (timeout_hit) begin
                    state_next = ST_FIN;
                end
            end
            ST_RD2: begin
                state_next = ST_FIN;
            end
            ST_FIN: begin
                fin        = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Transfer context: grant latch, timeout counter and read assembly.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            last_gnt <= 1'b1;
            owner    <= 1'b0;
            cmd_q    <= 3'd0;
            addr_q   <= 19'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            tcnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_any) begin
                        owner    <= gnt_id;
                        last_gnt <= gnt_id;
                        cmd_q    <= gnt_cmd;
                        addr_q   <= gnt_id ? ADDR_1 : ADDR_0;
                        wdata_q  <= gnt_id ? WDATA_1 : WDATA_0;
                        rdata_q  <= 32'd0;
                        err_q    <= 1'b0;
                    end
                end
                ST_CMD2: begin
                    tcnt <= '0;
                end
                ST_WAIT: begin
                    if (resp_seen) begin
                        case (cmd_q)
                            CMD_READ8:  rdata_q <= {24'd0, D1[7:0]};
                            CMD_READ16: rdata_q <= {16'd0, D1[7:0], D1[15:8]};
                            CMD_READ32: rdata_q[31:16] <= {D1[7:0], D1[15:8]};
                            default:    rdata_q <= 32'd0;
                        endcase
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= 32'd0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_RD2: begin
                    rdata_q[15:0] <= {D1[7:0], D1[15:8]};
                end
                default: begin
                    tcnt <= tcnt;
                end
            endcase
        end
    end

endmodule
